// File: rtl/spi_param_writer.sv
// Frame parser between the SPI slave byte stream and the mixer parameter memory.
// Frames are: command byte, 16-bit big-endian start address, then big-endian data words.
module spi_param_writer #(
  parameter int          DATA_WIDTH = 32,
  parameter int          ADDR_WIDTH = 10,
  parameter logic [7:0]  CMD_WRITE  = 8'h01
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  frame_active,
  input  logic [7:0]            rx_byte,
  input  logic                  rx_valid,
  output logic                  wr_en,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic [DATA_WIDTH-1:0] wr_data,
  output logic                  frame_done,
  output logic                  frame_error,
  output logic [15:0]           word_count
);

  localparam int BYTES = DATA_WIDTH / 8;
  localparam int CNT_W = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam logic [CNT_W-1:0] LAST_BYTE = CNT_W'(BYTES - 1);

  typedef enum logic [2:0] {
    ST_CMD     = 3'd0,
    ST_ADDR_HI = 3'd1,
    ST_ADDR_LO = 3'd2,
    ST_DATA    = 3'd3,
    ST_DISCARD = 3'd4
  } state_t;

  state_t                state_r;
  logic                  frame_active_d_r;
  logic [7:0]            addr_hi_r;
  logic [ADDR_WIDTH-1:0] addr_r;
  logic [CNT_W-1:0]      byte_cnt_r;
  logic [DATA_WIDTH-1:0] shift_r;
  logic [15:0]           run_count_r;
  logic                  wr_en_r;
  logic [ADDR_WIDTH-1:0] wr_addr_r;
  logic [DATA_WIDTH-1:0] wr_data_r;
  logic                  frame_done_r;
  logic                  frame_error_r;
  logic [15:0]           word_count_r;

  logic accept_s;
  logic frame_end_s;
  logic end_error_s;

  // A strobe in the cycle frame_active drops is not accepted, so accept and frame end never coincide.
  assign accept_s    = rx_valid & frame_active;
  assign frame_end_s = frame_active_d_r & ~frame_active;

  // Frame status if the frame were to end in the current state.
  always_comb begin
    end_error_s = 1'b1;
    case (state_r)
      ST_CMD:     end_error_s = 1'b1;
      ST_ADDR_HI: end_error_s = 1'b1;
      ST_ADDR_LO: end_error_s = 1'b1;
      ST_DATA:    end_error_s = (byte_cnt_r != {CNT_W{1'b0}});
      ST_DISCARD: end_error_s = 1'b1;
      default:    end_error_s = 1'b1;
    endcase
  end

  // Frame parser FSM with registered write and status outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r          <= ST_CMD;
      frame_active_d_r <= 1'b0;
      addr_hi_r        <= 8'h00;
      addr_r           <= {ADDR_WIDTH{1'b0}};
      byte_cnt_r       <= {CNT_W{1'b0}};
      shift_r          <= {DATA_WIDTH{1'b0}};
      run_count_r      <= 16'h0000;
      wr_en_r          <= 1'b0;
      wr_addr_r        <= {ADDR_WIDTH{1'b0}};
      wr_data_r        <= {DATA_WIDTH{1'b0}};
      frame_done_r     <= 1'b0;
      frame_error_r    <= 1'b0;
      word_count_r     <= 16'h0000;
    end else begin
      frame_active_d_r <= frame_active;
      wr_en_r          <= 1'b0;
      frame_done_r     <= 1'b0;
      if (frame_end_s) begin
        frame_done_r  <= 1'b1;
        frame_error_r <= end_error_s;
        word_count_r  <= run_count_r;
        state_r       <= ST_CMD;
        byte_cnt_r    <= {CNT_W{1'b0}};
        shift_r       <= {DATA_WIDTH{1'b0}};
        run_count_r   <= 16'h0000;
      end else if (accept_s) begin
        case (state_r)
          ST_CMD: begin
            state_r <= (rx_byte == CMD_WRITE) ? ST_ADDR_HI : ST_DISCARD;
          end
          ST_ADDR_HI: begin
            addr_hi_r <= rx_byte;
            state_r   <= ST_ADDR_LO;
          end
          ST_ADDR_LO: begin
            // Address bits above ADDR_WIDTH are dropped by the truncating cast.
            addr_r     <= ADDR_WIDTH'({addr_hi_r, rx_byte});
            byte_cnt_r <= {CNT_W{1'b0}};
            state_r    <= ST_DATA;
          end
          ST_DATA: begin
            shift_r <= DATA_WIDTH'({shift_r, rx_byte});
            if (byte_cnt_r == LAST_BYTE) begin
              wr_en_r    <= 1'b1;
              wr_addr_r  <= addr_r;
              wr_data_r  <= DATA_WIDTH'({shift_r, rx_byte});
              addr_r     <= addr_r + ADDR_WIDTH'(1);
              byte_cnt_r <= {CNT_W{1'b0}};
              if (run_count_r != 16'hFFFF) begin
                run_count_r <= run_count_r + 16'd1;
              end else begin
                run_count_r <= run_count_r;
              end
            end else begin
              byte_cnt_r <= byte_cnt_r + CNT_W'(1);
            end
          end
          ST_DISCARD: begin
            state_r <= ST_DISCARD;
          end
          default: begin
            state_r <= ST_DISCARD;
          end
        endcase
      end else begin
        state_r <= state_r;
      end
    end
  end

  assign wr_en       = wr_en_r;
  assign wr_addr     = wr_addr_r;
  assign wr_data     = wr_data_r;
  assign frame_done  = frame_done_r;
  assign frame_error = frame_error_r;
  assign word_count  = word_count_r;

endmodule

// File: tb/tb_spi_param_writer.sv
// Scoreboard bench for spi_param_writer: a byte-level frame model queues expected
// writes and frame status, and a negedge monitor pops and compares them.
module tb_spi_param_writer;

  localparam int          DW  = 32;
  localparam int          AW  = 10;
  localparam logic [7:0]  CMD = 8'h01;

  logic          clk;
  logic          reset_n;
  logic          frame_active;
  logic [7:0]    rx_byte;
  logic          rx_valid;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic          frame_done;
  logic          frame_error;
  logic [15:0]   word_count;

  spi_param_writer #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .CMD_WRITE(CMD)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .frame_active (frame_active),
    .rx_byte      (rx_byte),
    .rx_valid     (rx_valid),
    .wr_en        (wr_en),
    .wr_addr      (wr_addr),
    .wr_data      (wr_data),
    .frame_done   (frame_done),
    .frame_error  (frame_error),
    .word_count   (word_count)
  );

  typedef struct { logic [AW-1:0] a; logic [DW-1:0] d; int c; } wr_t;
  typedef struct { logic err; logic [15:0] cnt; int c; } fr_t;

  wr_t        wr_q[$];
  fr_t        fr_q[$];
  wr_t        wr_e;
  fr_t        fr_e;
  logic [7:0] byte_q[$];
  int         cyc = 0;
  int         n_checks = 0;
  int         n_errors = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  // Monitor: every write and every frame_done must match the head of its queue.
  always @(negedge clk) begin
    if (reset_n) begin
      if (wr_en) begin
        if (wr_q.size() == 0) begin
          check_val("wr_unexpected", {wr_addr, wr_data}, 64'd0);
        end else begin
          wr_e = wr_q.pop_front();
          check_val("wr_addr", wr_addr, wr_e.a);
          check_val("wr_data", wr_data, wr_e.d);
          check_val("wr_latency", cyc, wr_e.c);
        end
      end
      if (frame_done) begin
        if (fr_q.size() == 0) begin
          check_val("done_unexpected", 64'd1, 64'd0);
        end else begin
          fr_e = fr_q.pop_front();
          check_val("frame_error", frame_error, fr_e.err);
          check_val("word_count", word_count, fr_e.cnt);
          check_val("done_latency", cyc, fr_e.c);
        end
      end
    end
  end

  // Drive byte_q as one frame, modelling the expected writes and status as bytes go out.
  task automatic send_frame(input int max_gap, input bit strobe_on_fall);
    logic [7:0]    cmd_b;
    logic [15:0]   addr16;
    logic [AW-1:0] awork;
    logic [DW-1:0] word;
    int            bcnt;
    int            wc;
    int            n;
    int            gap;
    wr_t           w;
    fr_t           f;
    cmd_b = 8'h00; addr16 = 16'h0000; awork = '0; word = '0;
    bcnt = 0; wc = 0; n = 0;
    @(negedge clk);
    frame_active = 1'b1;
    foreach (byte_q[i]) begin
      @(negedge clk);
      rx_byte  = byte_q[i];
      rx_valid = 1'b1;
      if (n == 0) cmd_b = byte_q[i];
      else if (cmd_b == CMD) begin
        if (n == 1) addr16[15:8] = byte_q[i];
        else if (n == 2) begin
          addr16[7:0] = byte_q[i];
          awork = addr16[AW-1:0];
        end else begin
          word = {word[DW-9:0], byte_q[i]};
          bcnt++;
          if (bcnt == DW / 8) begin
            w.a = awork; w.d = word; w.c = cyc + 1;
            wr_q.push_back(w);
            awork = awork + 1'b1;
            wc++;
            bcnt = 0;
          end
        end
      end
      n++;
      gap = $urandom_range(max_gap, 0);
      if (gap > 0) begin
        @(negedge clk);
        rx_valid = 1'b0;
        repeat (gap - 1) @(negedge clk);
      end
    end
    @(negedge clk);
    frame_active = 1'b0;
    rx_valid     = strobe_on_fall;
    rx_byte      = 8'hB1;
    f.err = (n == 0) || (cmd_b != CMD) || (n < 3) || (bcnt != 0);
    f.cnt = 16'(wc);
    f.c   = cyc + 1;
    fr_q.push_back(f);
    @(negedge clk);
    rx_valid = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    reset_n = 1'b0; frame_active = 1'b0; rx_valid = 1'b0; rx_byte = 8'h00;
    repeat (3) @(negedge clk);
    check_val("reset_outputs", {wr_en, wr_addr, wr_data, frame_done, frame_error, word_count}, 64'd0);
    reset_n = 1'b1;
    repeat (3) @(negedge clk);
    check_val("release_outputs", {wr_en, wr_addr, wr_data, frame_done, frame_error, word_count}, 64'd0);

    // Two back-to-back words.
    byte_q = '{8'h01, 8'h00, 8'h05, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h12, 8'h34, 8'h56, 8'h78};
    send_frame(0, 1'b0);
    // Address wrap from 10'h3FF to 0, upper address bits dropped.
    byte_q = '{8'h01, 8'h03, 8'hFF, 8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h11, 8'h22, 8'h33, 8'h44};
    send_frame(2, 1'b0);
    byte_q = '{8'hFF, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    byte_q = '{8'h01, 8'hFC, 8'h07, 8'h01, 8'h02, 8'h03, 8'h04};
    send_frame(1, 1'b0);
    // Partial word, then a clean frame that must not inherit the leftover bytes.
    byte_q = '{8'h01, 8'h00, 8'h10, 8'h11, 8'h22, 8'h33};
    send_frame(1, 1'b0);
    byte_q = '{8'h01, 8'h00, 8'h10, 8'h44, 8'h55, 8'h66, 8'h77};
    send_frame(0, 1'b0);
    // Discard command, empty frame, header-only frames.
    byte_q = '{8'h7F, 8'h00, 8'h00, 8'hAA, 8'hBB, 8'hCC, 8'hDD};
    send_frame(1, 1'b0);
    byte_q = {};
    send_frame(0, 1'b0);
    byte_q = '{8'h01, 8'h00};
    send_frame(0, 1'b0);
    byte_q = '{8'h01, 8'h00, 8'h08};
    send_frame(0, 1'b0);
    // Strobe in the cycle frame_active falls must be ignored.
    byte_q = '{8'h01, 8'h00, 8'h40, 8'hA1, 8'hA2, 8'hA3, 8'hA4};
    send_frame(0, 1'b1);

    // Reset mid-frame after the address: nothing written, no frame_done.
    @(negedge clk);
    frame_active = 1'b1;
    byte_q = '{8'h01, 8'h00, 8'h20, 8'h99};
    foreach (byte_q[i]) begin
      @(negedge clk);
      rx_byte = byte_q[i]; rx_valid = 1'b1;
    end
    @(negedge clk);
    rx_valid = 1'b0;
    reset_n  = 1'b0;
    repeat (2) @(negedge clk);
    check_val("midframe_reset_outputs", {wr_en, wr_addr, wr_data, frame_done, frame_error, word_count}, 64'd0);
    // Release with frame_active already high: parsing starts from the command byte.
    reset_n = 1'b1;
    @(negedge clk);
    byte_q = '{8'h01, 8'h00, 8'h20, 8'hCA, 8'hFE, 8'hBA, 8'hBE};
    send_frame(1, 1'b0);

    for (int k = 0; k < 20 && (wr_q.size() != 0 || fr_q.size() != 0); k++) @(negedge clk);
    check_val("wr_queue_drained", wr_q.size(), 64'd0);
    check_val("frame_queue_drained", fr_q.size(), 64'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no end of stimulus, expected finish before 200000");
    $fatal(1, "timeout");
  end

endmodule
